// File: rtl/warp_scan_ctrl.sv
// Raster scan sequencer: issues homography requests per output pixel and writes results.
// Optional WARP_TIMEOUT_EN adds a wait-cycle watchdog that writes black and flags a sticky timeout.
module warp_scan_ctrl #(
    parameter int H_RES       = 640,
    parameter int V_RES       = 480,
    parameter int TIMEOUT_CYC = 1023
) (
    input  logic        iCLK,
    input  logic        iRST_N,
    input  logic        iFRAME_START,
    output logic [9:0]  oX,
    output logic [9:0]  oY,
    output logic        oSTART,
    input  logic        iREADY,
    input  logic [4:0]  iR,
    input  logic [5:0]  iG,
    input  logic [4:0]  iB,
    output logic        oWR_REQ,
    output logic [18:0] oWR_ADDR,
    output logic [15:0] oWR_DATA,
    input  logic        iWR_ACK,
    output logic        oBUSY,
    output logic        oFRAME_DONE,
    output logic        oTIMEOUT
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_WRITE,
        S_NEXT
    } state_t;

    localparam logic [9:0] X_LAST = 10'(H_RES - 1);
    localparam logic [9:0] Y_LAST = 10'(V_RES - 1);

    state_t      state_q, state_d;
    logic [9:0]  x_q, x_d;
    logic [9:0]  y_q, y_d;
    logic [18:0] addr_q, addr_d;
    logic [15:0] data_q, data_d;
    logic        last_px;

`ifdef WARP_TIMEOUT_EN
    localparam logic [9:0] TMO_LAST = 10'(TIMEOUT_CYC - 1);
    logic [9:0] tcnt_q, tcnt_d;
    logic       tmo_q, tmo_d;
`endif

    assign last_px = (x_q == X_LAST) && (y_q == Y_LAST);

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        addr_d  = addr_q;
        data_d  = data_q;
`ifdef WARP_TIMEOUT_EN
        tcnt_d  = tcnt_q;
        tmo_d   = tmo_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (iFRAME_START) begin
                    x_d     = '0;
                    y_d     = '0;
                    addr_d  = '0;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
`ifdef WARP_TIMEOUT_EN
                tcnt_d  = '0;
`endif
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (iREADY) begin
                    data_d  = {iR, iG, iB};
                    state_d = S_WRITE;
                end
`ifdef WARP_TIMEOUT_EN
                else if (tcnt_q == TMO_LAST) begin
                    data_d  = '0;
                    tmo_d   = 1'b1;
                    state_d = S_WRITE;
                end else begin
                    tcnt_d  = tcnt_q + 10'd1;
                end
`endif
            end
            S_WRITE: begin
                if (iWR_ACK) state_d = S_NEXT;
            end
            S_NEXT: begin
                addr_d = addr_q + 19'd1;
                if (x_q == X_LAST) begin
                    x_d = '0;
                    y_d = y_q + 10'd1;
                end else begin
                    x_d = x_q + 10'd1;
                end
                state_d = last_px ? S_IDLE : S_ISSUE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge iCLK) begin
        if (!iRST_N) begin
            state_q <= S_IDLE;
            x_q     <= '0;
            y_q     <= '0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

`ifdef WARP_TIMEOUT_EN
    always_ff @(posedge iCLK) begin
        if (!iRST_N) begin
            tcnt_q <= '0;
            tmo_q  <= 1'b0;
        end else begin
            tcnt_q <= tcnt_d;
            tmo_q  <= tmo_d;
        end
    end
    assign oTIMEOUT = tmo_q;
`else
    assign oTIMEOUT = 1'b0;
`endif

    // Done fires in the final S_NEXT so a start in that cycle lands outside S_IDLE.
    assign oFRAME_DONE = (state_q == S_NEXT) && last_px;
    assign oSTART      = (state_q == S_ISSUE);
    assign oWR_REQ     = (state_q == S_WRITE);
    assign oBUSY       = (state_q != S_IDLE);
    assign oX          = x_q;
    assign oY          = y_q;
    assign oWR_ADDR    = addr_q;
    assign oWR_DATA    = data_q;

endmodule

// File: doc/warp_scan_ctrl.md
WARP_SCAN_CTRL -- requirements
Module: warp_scan_ctrl

Interface
REQ-001 Parameter: H_RES, default 640, output frame width in pixels.
REQ-002 Parameter: V_RES, default 480, output frame height in pixels.
REQ-003 Parameter: TIMEOUT_CYC, default 1023, maximum wait cycles for a homography result (used only under WARP_TIMEOUT_EN).
REQ-004 iCLK  in  1  clock; all logic on the rising edge.
REQ-005 iRST_N  in  1  reset, synchronous, active-low.
REQ-006 iFRAME_START  in  1  start-of-frame request pulse.
REQ-007 oX, oY  out  10 each  output-pixel coordinate presented to the homography stage.
REQ-008 oSTART  out  1  homography start pulse.
REQ-009 iREADY  in  1  homography result valid.
REQ-010 iR, iB  in  5 each; iG  in  6  result colour from the homography stage.
REQ-011 oWR_REQ  out  1  frame-buffer write request.
REQ-012 oWR_ADDR  out  19  linear write address.
REQ-013 oWR_DATA  out  16  RGB565 write data.
REQ-014 iWR_ACK  in  1  frame-buffer write accept.
REQ-015 oBUSY  out  1  frame in progress.
REQ-016 oFRAME_DONE  out  1  one-cycle end-of-frame pulse.
REQ-017 oTIMEOUT  out  1  sticky timeout flag.

Function
REQ-018 The FSM SHALL have states S_IDLE, S_ISSUE, S_WAIT, S_WRITE and S_NEXT.
REQ-019 In S_IDLE, iFRAME_START=1 SHALL clear x, y and the address counter to 0 and move to S_ISSUE; otherwise the FSM SHALL stay in S_IDLE.
REQ-020 oSTART SHALL be high exactly during the single cycle in S_ISSUE; S_ISSUE SHALL always go to S_WAIT.
REQ-021 oX/oY SHALL equal the current x/y and SHALL stay stable from S_ISSUE until S_NEXT completes.
REQ-022 In S_WAIT, the first cycle with iREADY=1 SHALL capture oWR_DATA={iR,iG,iB} and move to S_WRITE; iREADY in any other state SHALL be ignored.
REQ-023 In S_WRITE, oWR_REQ SHALL be high and oWR_ADDR/oWR_DATA SHALL be held stable until the cycle iWR_ACK=1; that cycle SHALL move to S_NEXT, and oWR_REQ SHALL be low from the next cycle on.
REQ-024 oWR_ADDR SHALL equal y*H_RES+x, maintained by an incrementing counter (no multiplier); the counter SHALL advance by 1 per pixel.
REQ-025 In S_NEXT, if x<H_RES-1, x SHALL increment; otherwise x SHALL wrap to 0 and y SHALL increment.
REQ-026 From S_NEXT on the last pixel (x=H_RES-1, y=V_RES-1), oFRAME_DONE SHALL pulse for 1 cycle and the FSM SHALL enter S_IDLE; from any other pixel it SHALL go to S_ISSUE.
REQ-027 oBUSY SHALL be 1 in every state except S_IDLE.
REQ-028 iFRAME_START while oBUSY=1 SHALL be ignored, with no queuing.
REQ-029 iFRAME_START in the same cycle as the oFRAME_DONE pulse SHALL be ignored; a new frame starts only from a pulse sampled in S_IDLE.
REQ-030 Minimum per-pixel cost SHALL be 4 cycles (ISSUE, WAIT with immediate iREADY, WRITE with immediate ACK, NEXT).

Reset
REQ-031 iRST_N=0 at a rising edge SHALL force S_IDLE; x, y and the address counter to 0; and oX, oY, oSTART, oWR_REQ, oWR_ADDR, oWR_DATA, oBUSY, oFRAME_DONE, oTIMEOUT to 0.
REQ-032 Reset mid-frame SHALL abandon the frame with no oFRAME_DONE pulse; a pending write SHALL be dropped (oWR_REQ low on the next cycle).

Configuration
REQ-033 Macro WARP_TIMEOUT_EN: when defined, a 10-bit counter SHALL clear on entry to S_WAIT and count each S_WAIT cycle; on reaching TIMEOUT_CYC without iREADY, the block SHALL load oWR_DATA=16'h0000, set oTIMEOUT=1 until reset, and go to S_WRITE.
REQ-034 Without WARP_TIMEOUT_EN, the block SHALL wait in S_WAIT indefinitely, no counter logic SHALL exist, and oTIMEOUT SHALL be tied 0.

Verification
REQ-035 H_RES=4, V_RES=2, iREADY one cycle after each oSTART, iWR_ACK same cycle as oWR_REQ -> 8 writes at addresses 0..7, oX sequence 0,1,2,3,0,1,2,3, oY 0x4 then 1x4, one oFRAME_DONE, 32 cycles from S_ISSUE entry to S_IDLE.
REQ-036 iR=5'h1F, iG=6'h00, iB=5'h01 -> oWR_DATA=16'hF801; with iWR_ACK delayed 5 cycles, oWR_REQ/oWR_ADDR/oWR_DATA stay stable for all 6 cycles.
REQ-037 iFRAME_START pulsed mid-frame and in the oFRAME_DONE cycle -> no restart; pixel sequence unaffected; oBUSY=0 after the done cycle.
REQ-038 iRST_N low for 1 cycle during S_WRITE at pixel (2,1) -> all outputs 0 next cycle, no oFRAME_DONE; a following iFRAME_START restarts at address 0.
REQ-039 With WARP_TIMEOUT_EN and TIMEOUT_CYC=16, iREADY withheld for pixel 3 -> write of 16'h0000 at address 3, oTIMEOUT=1 sticky, frame still completes with 8 writes; without the macro the block stays in S_WAIT and oTIMEOUT=0.
